// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with self-clear after reset, loader write port and
// stall/flush fetch control. Optional macro INSTR_MEM_FAULT_EN enables misaligned/out-of-range fetch faults.
module instr_mem_sync #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_W-1:0]        pc_addr_i,
    input  logic                     rd_en_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     ld_we_i,
    input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]        ld_data_i,
    output logic                     ready_o,
    output logic [DATA_W-1:0]        instr_o,
    output logic                     instr_valid_o,
    output logic                     fault_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    clr_cnt_r;
    logic                ready_r;
    logic [DATA_W-1:0]   instr_r;
    logic                valid_r;
    logic                fault_r;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [IDX_W-1:0]    idx_s;
    logic [DATA_W-1:0]   rd_word_s;

`ifdef INSTR_MEM_FAULT_EN
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * 4);

    function automatic logic fetch_fault(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= MEM_BYTES);
    endfunction
`else
    // Upper and low address bits are deliberately ignored: fetches wrap modulo DEPTH*4.
    logic addr_unused_s;
    assign addr_unused_s = ^pc_addr_i;
`endif

    assign idx_s     = pc_addr_i[IDX_W+1:2];
    assign rd_word_s = mem_r[idx_s];

    // Select the single memory write source: clear sweep while clearing, loader once ready.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_cnt_r;
        mem_wdata_s = NOP_WORD;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_r;
                mem_wdata_s = NOP_WORD;
            end
            ST_READY: begin
                if (ld_we_i) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = ld_addr_i;
                    mem_wdata_s = ld_data_i;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Memory array; the fetch register samples the pre-write word, giving read-before-write.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Clear/ready FSM with registered fetch outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {IDX_W{1'b0}};
            ready_r   <= 1'b0;
            instr_r   <= NOP_WORD;
            valid_r   <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + IDX_W'(1);
                    if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (flush_i) begin
                        instr_r <= NOP_WORD;
                        valid_r <= 1'b0;
                        fault_r <= 1'b0;
                    end else if (stall_i) begin
                        instr_r <= instr_r;
                        valid_r <= valid_r;
                        fault_r <= fault_r;
                    end else if (rd_en_i) begin
`ifdef INSTR_MEM_FAULT_EN
                        if (fetch_fault(pc_addr_i)) begin
                            instr_r <= NOP_WORD;
                            valid_r <= 1'b1;
                            fault_r <= 1'b1;
                        end else begin
                            instr_r <= rd_word_s;
                            valid_r <= 1'b1;
                            fault_r <= 1'b0;
                        end
`else
                        instr_r <= rd_word_s;
                        valid_r <= 1'b1;
                        fault_r <= 1'b0;
`endif
                    end else begin
                        valid_r <= 1'b0;
                        fault_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= {IDX_W{1'b0}};
                    ready_r   <= 1'b0;
                    instr_r   <= NOP_WORD;
                    valid_r   <= 1'b0;
                    fault_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o       = ready_r;
    assign instr_o       = instr_r;
    assign instr_valid_o = valid_r;
    assign fault_o       = fault_r;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: an array-based reference model checked every cycle
// plus literal expectations for the key scenarios.
module tb_instr_mem_sync;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_i;
    logic [ADDR_W-1:0] pc_addr_i;
    logic              rd_en_i;
    logic              stall_i;
    logic              flush_i;
    logic              ld_we_i;
    logic [4:0]        ld_addr_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ready_o;
    logic [DATA_W-1:0] instr_o;
    logic              instr_valid_o;
    logic              fault_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_edges;
    logic              m_ready;
    logic [DATA_W-1:0] m_instr;
    logic              m_valid;
    logic              m_fault;

    instr_mem_sync #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pc_addr_i    (pc_addr_i),
        .rd_en_i      (rd_en_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .ld_we_i      (ld_we_i),
        .ld_addr_i    (ld_addr_i),
        .ld_data_i    (ld_data_i),
        .ready_o      (ready_o),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .fault_o      (fault_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // After a completed clear the whole memory reads as NOP and nothing is valid.
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0000_0000;
        m_edges = 0;
        m_ready = 1'b0;
        m_instr = 32'h0000_0000;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    function automatic bit model_fault(input logic [ADDR_W-1:0] pc);
`ifdef INSTR_MEM_FAULT_EN
        return ((pc % 4) != 0) || (pc >= DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    // Model update: memory as an array, outputs from the fetch priority rules.
    always @(posedge clk) begin
        if (rst_i === 1'b1) begin
            if (!m_ready) begin
                m_edges++;
                if (m_edges == DEPTH) m_ready = 1'b1;
            end else begin
                if (flush_i) begin
                    m_instr = 32'h0000_0000;
                    m_valid = 1'b0;
                    m_fault = 1'b0;
                end else if (stall_i) begin
                    m_valid = m_valid;
                end else if (rd_en_i) begin
                    m_valid = 1'b1;
                    if (model_fault(pc_addr_i)) begin
                        m_instr = 32'h0000_0000;
                        m_fault = 1'b1;
                    end else begin
                        m_instr = m_mem[(pc_addr_i / 4) % DEPTH];
                        m_fault = 1'b0;
                    end
                end else begin
                    m_valid = 1'b0;
                    m_fault = 1'b0;
                end
                if (ld_we_i) m_mem[ld_addr_i] = ld_data_i;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_ready", 32'(ready_o), 32'(m_ready));
            check("cyc_valid", 32'(instr_valid_o), 32'(m_valid));
            check("cyc_instr", instr_o, m_instr);
            check("cyc_fault", 32'(fault_o), 32'(m_fault));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int expect_edges);
        int cnt;
        cnt = 0;
        while (ready_o !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            if (ready_o !== 1'b1) check({name, "_valid_low"}, 32'(instr_valid_o), 32'd0);
        end
        check({name, "_edges"}, 32'(cnt), 32'(expect_edges));
    endtask

    task automatic fetch(input logic [31:0] pc);
        pc_addr_i = pc;
        rd_en_i   = 1'b1;
        tick();
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        rd_en_i   = 1'b0;
        ld_we_i   = 1'b1;
        ld_addr_i = a;
        ld_data_i = d;
        tick();
        ld_we_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i     = 1'b0;
        pc_addr_i = 32'd0;
        rd_en_i   = 1'b1;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        ld_we_i   = 1'b0;
        ld_addr_i = 5'd0;
        ld_data_i = 32'd0;
        model_reset();
        #1;
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0000_0000);
        check("rst_fault", 32'(fault_o), 32'd0);
        tick();
        tick();
        cmp_en = 1'b1;

        // 1: clear takes DEPTH edges with rd_en held high
        rst_i = 1'b1;
        wait_ready("clear1", 32);
        fetch(32'd20);
        check("t1_instr", instr_o, 32'h0000_0000);
        check("t1_valid", 32'(instr_valid_o), 32'd1);

        // 2: loader then fetch, including wrapped address
        load(5'd3, 32'h2001_0005);
        fetch(32'd12);
        check("t2_instr", instr_o, 32'h2001_0005);
        check("t2_valid", 32'(instr_valid_o), 32'd1);
`ifndef INSTR_MEM_FAULT_EN
        fetch(32'd140);
        check("t2_wrap", instr_o, 32'h2001_0005);
        fetch(32'd15);
        check("t2_misalign", instr_o, 32'h2001_0005);
`endif

        // 3: read-before-write on the same index
        ld_we_i   = 1'b1;
        ld_addr_i = 5'd3;
        ld_data_i = 32'hAAAA_AAAA;
        fetch(32'd12);
        ld_we_i   = 1'b0;
        check("t3_old", instr_o, 32'h2001_0005);
        fetch(32'd12);
        check("t3_new", instr_o, 32'hAAAA_AAAA);

        // 4: stall holds while pc moves; a load during stall still lands
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_we_i   = (i == 1);
            ld_addr_i = 5'd7;
            ld_data_i = 32'hDEAD_BEEF;
            fetch(32'd20 + 32'(i) * 32'd4);
            check("t4_stall_instr", instr_o, 32'hAAAA_AAAA);
            check("t4_stall_valid", 32'(instr_valid_o), 32'd1);
        end
        ld_we_i = 1'b0;
        flush_i = 1'b1;
        fetch(32'd28);
        check("t4_flush_instr", instr_o, 32'h0000_0000);
        check("t4_flush_valid", 32'(instr_valid_o), 32'd0);
        stall_i = 1'b0;
        flush_i = 1'b0;
        fetch(32'd28);
        check("t4_load_in_stall", instr_o, 32'hDEAD_BEEF);
        rd_en_i = 1'b0;
        tick();
        check("t4_idle_valid", 32'(instr_valid_o), 32'd0);
        check("t4_idle_hold", instr_o, 32'hDEAD_BEEF);

        // 5: asynchronous reset mid-stream, loader ignored while clearing
        fetch(32'd12);
        rst_i = 1'b0;
        model_reset();
        #1;
        check("t5_async_valid", 32'(instr_valid_o), 32'd0);
        check("t5_async_ready", 32'(ready_o), 32'd0);
        check("t5_async_instr", instr_o, 32'h0000_0000);
        tick();
        ld_we_i   = 1'b1;
        ld_addr_i = 5'd5;
        ld_data_i = 32'hFFFF_FFFF;
        rst_i     = 1'b1;
        wait_ready("clear2", 32);
        ld_we_i = 1'b0;
        fetch(32'd12);
        check("t5_cleared3", instr_o, 32'h0000_0000);
        fetch(32'd28);
        check("t5_cleared7", instr_o, 32'h0000_0000);
        fetch(32'd20);
        check("t5_clear_ld", instr_o, 32'h0000_0000);

`ifdef INSTR_MEM_FAULT_EN
        // 6: fault detection
        load(5'd3, 32'h2001_0005);
        fetch(32'd6);
        check("t6_mis_fault", 32'(fault_o), 32'd1);
        check("t6_mis_instr", instr_o, 32'h0000_0000);
        check("t6_mis_valid", 32'(instr_valid_o), 32'd1);
        stall_i = 1'b1;
        fetch(32'd12);
        check("t6_stall_hold", 32'(fault_o), 32'd1);
        stall_i = 1'b0;
        fetch(32'd128);
        check("t6_range_fault", 32'(fault_o), 32'd1);
        fetch(32'd12);
        check("t6_ok_fault", 32'(fault_o), 32'd0);
        check("t6_ok_instr", instr_o, 32'h2001_0005);
`endif

        rd_en_i = 1'b0;
        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
